// File: rtl/bandai_mapper_gen2_if.sv
// Cartridge-side bus bundle for the Bandai gen2 mapper.
// GPIO_EN adds the four general-purpose IO lines.
interface bandai_mapper_gen2_if #(parameter int RADDR_W = 7);
  logic               CEn, WEn, OEn, SSn;
  logic [7:0]         ADDR, DQ_I, DQ_O;
  logic               DQ_OE, SO, ROMCEn, RAMCEn, UNLOCKED;
  logic [RADDR_W-1:0] RADDR;
`ifdef GPIO_EN
  logic [3:0]         IO_I, IO_O, IO_OE;

  modport master (output CEn, WEn, OEn, SSn, ADDR, DQ_I, IO_I,
                  input  DQ_O, DQ_OE, SO, ROMCEn, RAMCEn, RADDR, UNLOCKED, IO_O, IO_OE);
  modport slave  (input  CEn, WEn, OEn, SSn, ADDR, DQ_I, IO_I,
                  output DQ_O, DQ_OE, SO, ROMCEn, RAMCEn, RADDR, UNLOCKED, IO_O, IO_OE);
`else
  modport master (output CEn, WEn, OEn, SSn, ADDR, DQ_I,
                  input  DQ_O, DQ_OE, SO, ROMCEn, RAMCEn, RADDR, UNLOCKED);
  modport slave  (input  CEn, WEn, OEn, SSn, ADDR, DQ_I,
                  output DQ_O, DQ_OE, SO, ROMCEn, RAMCEn, RADDR, UNLOCKED);
`endif
endinterface

// File: rtl/bandai_mapper_gen2.sv
// Bandai gen2 mapper: unlock FSM, serial ID stream, bank registers and chip-enable decode.
// Define GPIO_EN to add the IOCTL/IOSCN registers and the IO pins.
module bandai_mapper_gen2 #(
  parameter int          NROMB    = 2,
  parameter int          RADDR_W  = 7,
  parameter int          BITS_LEN = 18,
  parameter logic [31:0] BITS     = 32'({1'b0, 16'h28A0, 1'b0})
) (
  input logic CLK,
  input logic RST,
  bandai_mapper_gen2_if.slave bus
);
  typedef enum logic [1:0] {LOCK0, LOCK1, OPEN} state_t;

  localparam logic [7:0] A_LAO   = 8'hC0;
  localparam logic [7:0] A_RAMB  = 8'hC1;
  localparam logic [7:0] A_ROMB  = 8'hC2;
  localparam logic [7:0] A_IOCTL = 8'hCC;
  localparam logic [7:0] A_IOSCN = 8'hCD;
  localparam logic [7:0] A_CTRL  = 8'hCF;

  state_t                 state, state_nxt;
  logic [BITS_LEN:0]      shreg;
  logic [7:0]             lao, ramb;
  logic [NROMB-1:0][7:0]  romb;
  logic [7:0]             cap_addr, cap_data;
  logic                   cap_ok, we_prev;
  logic                   commit, lock_req, open, bus_sel, rce, rd_hit;
  logic [7:0]             rd_val;
  logic [3:0]             win;
  logic [RADDR_W-1:0]     raddr;

  assign open     = (state == OPEN);
  assign bus_sel  = ~(bus.SSn & bus.CEn);
  assign commit   = bus.WEn & ~we_prev & cap_ok;
  assign lock_req = commit & (cap_addr == A_CTRL) & cap_data[0];

  always_ff @(posedge CLK) begin
    if (RST) state <= LOCK0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOCK0: if (bus.ADDR == 8'h5A) state_nxt = LOCK1;
      LOCK1: begin
        if (bus.ADDR == 8'hA5)      state_nxt = OPEN;
        else if (bus.ADDR != 8'h5A) state_nxt = LOCK0;
      end
      default: state_nxt = state;
    endcase
    if (lock_req) state_nxt = LOCK0;
  end

  // Extra top bit is a constant 1 so the shift also works for BITS_LEN==1.
  always_ff @(posedge CLK) begin
    if (RST || state_nxt != OPEN) shreg <= '1;
    else if (state != OPEN)       shreg <= {1'b1, BITS[BITS_LEN-1:0]};
    else                          shreg <= {1'b1, shreg[BITS_LEN:1]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_addr <= '0;
      cap_data <= '0;
      cap_ok   <= 1'b0;
      we_prev  <= 1'b1;
      lao      <= '1;
      ramb     <= '1;
      romb     <= '1;
    end else begin
      we_prev <= bus.WEn;
      if (!bus.WEn) begin
        cap_addr <= bus.ADDR;
        cap_data <= bus.DQ_I;
        cap_ok   <= open & bus_sel;
      end
      if (commit) begin
        if (cap_addr == A_LAO)  lao  <= cap_data;
        if (cap_addr == A_RAMB) ramb <= cap_data;
        for (int i = 0; i < NROMB; i++)
          if (cap_addr == A_ROMB + 8'(i)) romb[i] <= cap_data;
      end
    end
  end

`ifdef GPIO_EN
  logic [3:0] ioctl, ioscn, ioscn_rd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ioctl <= '0;
      ioscn <= '0;
    end else if (commit) begin
      if (cap_addr == A_IOCTL) ioctl <= cap_data[3:0];
      if (cap_addr == A_IOSCN) ioscn <= cap_data[3:0];
    end
  end

  // Pins configured as inputs read back the live pin level.
  assign ioscn_rd  = (ioctl & ioscn) | (~ioctl & bus.IO_I);
  assign bus.IO_OE = ioctl;
  assign bus.IO_O  = ioscn;
`endif

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    case (bus.ADDR)
      A_LAO:   begin rd_hit = 1'b1; rd_val = lao;  end
      A_RAMB:  begin rd_hit = 1'b1; rd_val = ramb; end
      A_CTRL:  rd_hit = 1'b1;
`ifdef GPIO_EN
      A_IOCTL: begin rd_hit = 1'b1; rd_val = {4'h0, ioctl};    end
      A_IOSCN: begin rd_hit = 1'b1; rd_val = {4'h0, ioscn_rd}; end
`endif
      default: ;
    endcase
    for (int i = 0; i < NROMB; i++)
      if (bus.ADDR == A_ROMB + 8'(i)) begin
        rd_hit = 1'b1;
        rd_val = romb[i];
      end
  end

  assign bus.DQ_OE = open & bus_sel & ~bus.OEn & bus.WEn & rd_hit;
  assign bus.DQ_O  = bus.DQ_OE ? rd_val : 8'h00;

  assign win        = bus.ADDR[7:4];
  assign rce        = open & bus.SSn & ~bus.CEn;
  assign bus.RAMCEn = ~(rce & (win == 4'd1));
  assign bus.ROMCEn = ~(rce & (win >= 4'd2));

  // Windows above the last ROM bank are linear: LAO supplies the high bits.
  always_comb begin
    raddr = '0;
    if (rce && win == 4'd1) raddr = ramb[RADDR_W-1:0];
    else if (rce && win >= 4'd2) begin
      raddr = {lao[RADDR_W-5:0], win};
      for (int i = 0; i < NROMB; i++)
        if (win == 4'(i + 2)) raddr = romb[i][RADDR_W-1:0];
    end
  end

  assign bus.RADDR    = raddr;
  assign bus.SO       = shreg[0];
  assign bus.UNLOCKED = open;
endmodule
